idma_obi_arbiter: RTL
=====================

IDMA_OBI_ARBITER -- requirements
Module: idma_obi_arbiter

Interface
REQ-001 SHALL have parameters: NumReq, default 4, number of OBI requesters (2..8); AddrWidth, default 32, address width; DataWidth, default 32, data width; MaxOutst, default 4, outstanding-transaction limit (power of 2).
REQ-002 SHALL have ports, clock and reset first:
 clk_i  in  1  sole clock, rising edge
 rst_i  in  1  reset, synchronous, active-high
 req_i  in  NumReq  per-requester address-phase request
 addr_i  in  NumReq*AddrWidth  per-requester address
 we_i  in  NumReq  per-requester write enable
 wdata_i  in  NumReq*DataWidth  per-requester write data
 be_i  in  NumReq*DataWidth/8  per-requester byte enables
 gnt_o  out  NumReq  per-requester grant
 rvalid_o  out  NumReq  per-requester response valid
 rready_i  in  NumReq  per-requester response ready
 rdata_o  out  DataWidth  response data, shared by all requesters
 err_o  out  1  response error, shared by all requesters
 mst_req_o  out  1  downstream request to the OBI-to-AXI bridge
 mst_addr_o  out  AddrWidth  downstream address
 mst_we_o  out  1  downstream write enable
 mst_wdata_o  out  DataWidth  downstream write data
 mst_be_o  out  DataWidth/8  downstream byte enables
 mst_aid_o  out  clog2(NumReq)  downstream ID, equal to the granted requester index
 mst_gnt_i  in  1  downstream grant
 mst_rvalid_i  in  1  downstream response valid
 mst_rready_o  out  1  downstream response ready
 mst_rdata_i  in  DataWidth  downstream response data
 mst_err_i  in  1  downstream response error
 outst_o  out  clog2(MaxOutst)+1  count of outstanding transactions
 busy_o  out  1  high when outst_o is non-zero or mst_req_o is high

Function
REQ-003 SHALL arbitrate round-robin: a priority pointer ptr selects the first requester at or after ptr with req_i set.
REQ-004 SHALL advance ptr to (k+1) mod NumReq after a downstream handshake (mst_req_o and mst_gnt_i) for requester k; ptr otherwise holds.
REQ-005 SHALL implement the FSM ARB -> LOCK when mst_req_o=1 and mst_gnt_i=0, capturing the selected index; LOCK -> ARB on mst_gnt_i=1. LOCK holds the captured index regardless of other req_i changes.
REQ-006 SHALL drive mst_req_o=1 only when some req_i is set (or the FSM is in LOCK) and outst_o < MaxOutst.
REQ-007 SHALL drive all mst_* address-phase outputs combinationally from the selected requester, and mst_aid_o with its index.
REQ-008 SHALL assert gnt_o[k] = mst_gnt_i & mst_req_o for the selected k only; all other gnt_o bits stay 0. Grant latency is combinational (zero cycles).
REQ-009 SHALL push the granted index into an in-order ID FIFO of depth MaxOutst on each downstream handshake.
REQ-010 SHALL route responses to the FIFO head h: rvalid_o[h] = mst_rvalid_i, mst_rready_o = rready_i[h], rdata_o = mst_rdata_i, err_o = mst_err_i; pop the FIFO on mst_rvalid_i & mst_rready_o.
REQ-011 SHALL keep outst_o equal to pushes minus pops. A simultaneous push and pop leaves it unchanged.
REQ-012 SHALL suppress mst_req_o when outst_o == MaxOutst, even if a pop occurs in the same cycle.
REQ-013 SHALL hold rvalid_o at 0 and mst_rready_o at 0 when the FIFO is empty; a mst_rvalid_i in that case is a protocol error, flagged by assertion.
REQ-014 SHALL hold outputs stable while in LOCK; an assertion SHALL flag req_i[k] falling before gnt_o[k].

Reset
REQ-015 SHALL, while rst_i is high at a clk_i edge, set ptr=0, FSM=ARB, the FIFO empty, and outst_o=0. Consequently gnt_o=0, rvalid_o=0, mst_req_o=0 (when req_i=0), mst_rready_o=0, busy_o=0.
REQ-016 SHALL drop all in-flight tracking on reset mid-operation; responses arriving after reset are not forwarded.

Verification
REQ-017 Single requester: req_i=0001, addr=0x100, mst_gnt_i=1 -> gnt_o=0001 in the same cycle, mst_aid_o=0, outst_o=1; a response with rdata=0xCAFE0000 -> rvalid_o=0001, rdata_o=0xCAFE0000, outst_o=0.
REQ-018 Fairness: req_i=1111 held, mst_gnt_i=1 -> grant order 0,1,2,3,0 on consecutive cycles.
REQ-019 Lock: req_i=0011, mst_gnt_i=0 for 3 cycles with requester 0 selected; req_i[1] toggles meanwhile -> selection stays 0 and addr is stable; grant to requester 0 on the 4th cycle.
REQ-020 Full: MaxOutst=4, four grants with no responses -> mst_req_o=0 on the 5th request; one response popped -> mst_req_o=1 in the next cycle.
REQ-021 Ordering: grants to 2 then 0; two responses -> rvalid_o=0100 then 0001; rready_i[2]=0 stalls mst_rready_o=0.
REQ-022 Reset mid-flight: outst_o=3, rst_i=1 for one cycle -> outst_o=0, busy_o=0, ptr=0.

Source files
------------

// File: rtl/idma_obi_arbiter.sv
// rtl/idma_obi_arbiter.sv - round-robin OBI arbiter with in-order response routing
module idma_obi_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxOutst  = 4,
  localparam int unsigned IdxW     = $clog2(NumReq),
  localparam int unsigned CntW     = $clog2(MaxOutst) + 1,
  localparam int unsigned PtrW     = (MaxOutst > 1) ? $clog2(MaxOutst) : 1,
  localparam int unsigned BeW      = DataWidth / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq*AddrWidth-1:0] addr_i,
  input  logic [NumReq-1:0]           we_i,
  input  logic [NumReq*DataWidth-1:0] wdata_i,
  input  logic [NumReq*BeW-1:0]       be_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic [NumReq-1:0]           rvalid_o,
  input  logic [NumReq-1:0]           rready_i,
  output logic [DataWidth-1:0]        rdata_o,
  output logic                        err_o,
  output logic                        mst_req_o,
  output logic [AddrWidth-1:0]        mst_addr_o,
  output logic                        mst_we_o,
  output logic [DataWidth-1:0]        mst_wdata_o,
  output logic [BeW-1:0]              mst_be_o,
  output logic [IdxW-1:0]             mst_aid_o,
  input  logic                        mst_gnt_i,
  input  logic                        mst_rvalid_i,
  output logic                        mst_rready_o,
  input  logic [DataWidth-1:0]        mst_rdata_i,
  input  logic                        mst_err_i,
  output logic [CntW-1:0]             outst_o,
  output logic                        busy_o
);

  typedef enum logic [0:0] {ARB, LOCK} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   lock_idx_q;
  logic [IdxW-1:0]   rr_idx;
  logic [IdxW-1:0]   cand;
  logic              rr_found;
  logic [IdxW-1:0]   sel_idx;
  logic [IdxW-1:0]   ptr_nxt;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [IdxW-1:0]   id_q [MaxOutst];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   outst_q;
  logic [IdxW-1:0]   head_idx;

  // Round-robin search: first requesting index at or after the priority pointer.
  always_comb begin
    rr_idx   = ptr_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(ptr_q) + 32'(i)) % NumReq);
      if (!rr_found && req_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // A stalled request keeps its captured index until the bridge grants it.
  assign sel_idx   = (state_q == LOCK) ? lock_idx_q : rr_idx;
  assign full      = (outst_q == CntW'(MaxOutst));
  assign empty     = (outst_q == '0);
  assign mst_req_o = ((state_q == LOCK) || (|req_i)) && !full;
  assign push      = mst_req_o && mst_gnt_i;
  assign ptr_nxt   = (sel_idx == IdxW'(NumReq - 1)) ? '0 : sel_idx + 1'b1;

  assign mst_addr_o  = addr_i[sel_idx*AddrWidth +: AddrWidth];
  assign mst_we_o    = we_i[sel_idx];
  assign mst_wdata_o = wdata_i[sel_idx*DataWidth +: DataWidth];
  assign mst_be_o    = be_i[sel_idx*BeW +: BeW];
  assign mst_aid_o   = sel_idx;

  // Only the selected requester sees the downstream grant.
  always_comb begin
    gnt_o          = '0;
    gnt_o[sel_idx] = push;
  end

  // Lock FSM next state: an ungranted request freezes the selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (mst_req_o && !mst_gnt_i) state_d = LOCK;
      LOCK:    if (mst_gnt_i) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Responses return in order, so the FIFO head owns the response channel.
  assign head_idx     = id_q[rd_ptr_q];
  assign mst_rready_o = !empty && rready_i[head_idx];
  assign pop          = mst_rvalid_i && mst_rready_o;
  assign rdata_o      = mst_rdata_i;
  assign err_o        = mst_err_i;
  assign outst_o      = outst_q;
  assign busy_o       = !empty || mst_req_o;

  // Response valid is steered to the head requester only while tracking something.
  always_comb begin
    rvalid_o = '0;
    if (!empty) rvalid_o[head_idx] = mst_rvalid_i;
  end

  // Arbitration state, lock capture, FIFO pointers and outstanding count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      outst_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB && state_d == LOCK) lock_idx_q <= rr_idx;
      if (push) begin
        ptr_q    <= ptr_nxt;
        wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutst - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutst - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   outst_q <= outst_q + CntW'(1);
        2'b01:   outst_q <= outst_q - CntW'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  // ID storage needs no reset: entries are only read while counted as outstanding.
  always_ff @(posedge clk_i) begin
    if (push) id_q[wr_ptr_q] <= sel_idx;
  end

  // Protocol checks: responses need a tracked ID, a locked requester must hold its request.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(mst_rvalid_i && empty))
        else $error("response valid with no outstanding transaction");
      assert (!(state_q == LOCK && !req_i[lock_idx_q]))
        else $error("locked requester dropped its request before grant");
    end
  end

endmodule
